issue_scoreboard: RTL and testbench

Issue controller for the decode stage. Tracks in-flight register writes in a per-register scoreboard and decides each cycle whether the decoded instruction may issue into ID/EX. Otherwise it stalls IF/ID and inserts a bubble into ID/EX. It also sequences pipeline flushes on redirect. It sits beside the decoder, taking architectural register addresses from the instruction in IF/ID and retire events from writeback.

---
 rtl/issue_scoreboard_pkg.sv | 16 +
 rtl/issue_scoreboard_sb_counter_bank.sv | 64 ++++++
 rtl/issue_scoreboard.sv | 122 ++++++++++++
 tb/tb_issue_scoreboard.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared types and defaults for the decode-stage issue scoreboard.
package issue_scoreboard_pkg;

  localparam int NREG_DEF         = 32;
  localparam int CNT_W_DEF        = 2;
  localparam int FLUSH_CYCLES_DEF = 2;

  typedef logic [4:0] reg_addr;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } sb_state_t;

endpackage

// File: rtl/issue_scoreboard_sb_counter_bank.sv
// Per-register pending-write counters with one increment port, one decrement
// port and three combinational lookups (rs1, rs2, rd). Register 0 reads as 0.
module sb_counter_bank
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en_i,
  input  reg_addr          inc_addr_i,
  input  logic             dec_en_i,
  input  reg_addr          dec_addr_i,
  input  reg_addr          rs1_i,
  input  reg_addr          rs2_i,
  input  reg_addr          rd_i,
  output logic [CNT_W-1:0] pend_rs1_o,
  output logic [CNT_W-1:0] pend_rs2_o,
  output logic [CNT_W-1:0] pend_rd_o
);

  logic [CNT_W-1:0] pend_w [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        assign pend_w[gi] = '0;
      end else begin : g_reg
        logic [CNT_W-1:0] cnt_q;
        logic             inc_hit;
        logic             dec_hit;

        assign inc_hit = inc_en_i && (inc_addr_i == reg_addr'(gi));
        assign dec_hit = dec_en_i && (dec_addr_i == reg_addr'(gi));

        // Simultaneous inc and dec cancel; underflow and overflow hold.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            cnt_q <= '0;
          end else if (inc_hit && !dec_hit && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (dec_hit && !inc_hit && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        always @(posedge clk) begin
          if (!reset) begin
            assert (!(dec_hit && !inc_hit && (cnt_q == '0)));
          end
        end

        assign pend_w[gi] = cnt_q;
      end
    end
  endgenerate

  assign pend_rs1_o = pend_w[rs1_i];
  assign pend_rs2_o = pend_w[rs2_i];
  assign pend_rd_o  = pend_w[rd_i];

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage issue controller: RAW/structural hazard detection, stall/bubble
// generation and flush sequencing. ISSUE_SCOREBOARD_PERF_EN adds perf counters.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG         = NREG_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_writes_rd,
  input  logic        ex_busy,
  input  logic        wb_retire,
  input  logic [4:0]  wb_rd,
  input  logic        wb_wrote,
  input  logic        flush_req,
  output logic        id_ready,
  output logic        if_stall,
  output logic        idex_bubble,
  output logic        ifid_kill
`ifdef ISSUE_SCOREBOARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  sb_state_t        state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] pend_rs1, pend_rs2, pend_rd;
  logic             dec_en, inc_en;
  logic             haz_rs1, haz_rs2, haz_rd, hazard, stall_cond, ready_raw;

  assign dec_en = wb_retire && wb_wrote && (wb_rd != 5'd0);
  assign inc_en = ready_raw && id_writes_rd && (id_rd != 5'd0);

  sb_counter_bank #(.NREG(NREG), .CNT_W(CNT_W)) u_bank (
    .clk        (clk),
    .reset      (reset),
    .inc_en_i   (inc_en),
    .inc_addr_i (id_rd),
    .dec_en_i   (dec_en),
    .dec_addr_i (wb_rd),
    .rs1_i      (id_rs1),
    .rs2_i      (id_rs2),
    .rd_i       (id_rd),
    .pend_rs1_o (pend_rs1),
    .pend_rs2_o (pend_rs2),
    .pend_rd_o  (pend_rd)
  );

  // A source whose last producer retires this cycle is served by the WB forward.
  assign haz_rs1 = id_uses_rs1 && (id_rs1 != 5'd0) && (pend_rs1 != '0) &&
                   !(dec_en && (wb_rd == id_rs1) && (pend_rs1 == CNT_W'(1)));
  assign haz_rs2 = id_uses_rs2 && (id_rs2 != 5'd0) && (pend_rs2 != '0) &&
                   !(dec_en && (wb_rd == id_rs2) && (pend_rs2 == CNT_W'(1)));
  assign haz_rd  = id_writes_rd && (id_rd != 5'd0) && (&pend_rd);
  assign hazard  = haz_rs1 || haz_rs2 || haz_rd;
  assign stall_cond = id_valid && (hazard || ex_busy);

  assign ready_raw = id_valid && (state_q != FLUSH) && !flush_req && !hazard && !ex_busy;

  // Outputs are forced low while reset is held.
  assign id_ready    = !reset && ready_raw;
  assign if_stall    = !reset && id_valid && !ready_raw && (state_q != FLUSH) && !flush_req;
  assign idex_bubble = !reset && !ready_raw;
  assign ifid_kill   = !reset && flush_req;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (flush_req) begin
      state_d = FLUSH;
      fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
    end else begin
      case (state_q)
        RUN:     if (stall_cond) state_d = STALL;
        STALL:   if (!stall_cond) state_d = RUN;
        FLUSH: begin
          if (fcnt_q == '0) state_d = RUN;
          else              fcnt_d  = fcnt_q - 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef ISSUE_SCOREBOARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
      flush_count   <= '0;
    end else begin
      if (if_stall)                 stall_cycles  <= stall_cycles + 32'd1;
      if (idex_bubble && id_valid)  bubble_cycles <= bubble_cycles + 32'd1;
      if (flush_req)                flush_count   <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: expected {id_ready,if_stall,
// idex_bubble,ifid_kill} vectors are queued per cycle and compared at mid-cycle.
module tb_issue_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_writes_rd = 1'b0;
  logic       ex_busy = 1'b0, wb_retire = 1'b0, wb_wrote = 1'b0, flush_req = 1'b0;
  logic       id_ready, if_stall, idex_bubble, ifid_kill;
`ifdef ISSUE_SCOREBOARD_PERF_EN
  logic [31:0] stall_cycles, bubble_cycles, flush_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_writes_rd (id_writes_rd),
    .ex_busy      (ex_busy),
    .wb_retire    (wb_retire),
    .wb_rd        (wb_rd),
    .wb_wrote     (wb_wrote),
    .flush_req    (flush_req),
    .id_ready     (id_ready),
    .if_stall     (if_stall),
    .idex_bubble  (idex_bubble),
    .ifid_kill    (ifid_kill)
`ifdef ISSUE_SCOREBOARD_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles),
    .flush_count   (flush_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic w);
    id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1;
    id_rs2 = rs2; id_uses_rs2 = u2; id_rd = rd; id_writes_rd = w;
  endtask

  task automatic retire(input logic [4:0] r);
    wb_retire = 1'b1; wb_rd = r; wb_wrote = 1'b1;
  endtask

  // Inputs are applied 1 time unit after posedge; outputs sampled 3 units later.
  // Retire, flush and busy are single-cycle and cleared after each step.
  task automatic step(input string tag, input logic [3:0] exp);
    logic [3:0] obs, e;
    exp_q.push_back(exp);
    #3;
    obs = {id_ready, if_stall, idex_bubble, ifid_kill};
    e = exp_q.pop_front();
    check(tag, {28'd0, obs}, {28'd0, e});
    @(posedge clk); #1;
    wb_retire = 1'b0; wb_wrote = 1'b0; wb_rd = '0;
    flush_req = 1'b0; ex_busy = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    set_id(1, 1, 1, 0, 0, 0, 0);
    step("reset_outs", 4'b0000);
    reset = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    step("idle", 4'b0010);

    // RAW on x5, resolved by same-cycle retire
    set_id(1, 1, 1, 0, 0, 5, 1);  step("w_x5", 4'b1000);
    set_id(1, 5, 1, 0, 0, 6, 1);  step("raw_x5", 4'b0110);
    step("raw_x5_hold", 4'b0110);
    retire(5);                    step("raw_x5_bypass", 4'b1000);
    set_id(0, 0, 0, 0, 0, 0, 0);
    retire(6);                    step("ret_x6", 4'b0010);

    // two producers of x7: bypass only when the last one retires
    set_id(1, 0, 0, 0, 0, 7, 1);  step("w_x7a", 4'b1000);
    step("w_x7b", 4'b1000);
    set_id(1, 0, 0, 7, 1, 0, 0);
    retire(7);                    step("rd_x7_pend2", 4'b0110);
    retire(7);                    step("rd_x7_bypass", 4'b1000);

    // saturation of x9, reader of x0
    set_id(1, 0, 0, 0, 0, 9, 1);
    for (int i = 0; i < 3; i++) step("w_x9", 4'b1000);
    step("w_x9_sat", 4'b0110);
    retire(9);                    step("w_x9_sat_ret", 4'b0110);
    step("w_x9_refill", 4'b1000);
    set_id(1, 0, 1, 0, 1, 0, 0);  step("rd_x0", 4'b1000);
    set_id(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      retire(9);                  step("ret_x9", 4'b0010);
    end

    // flush during STALL, then a reflush mid-window
    set_id(1, 0, 0, 0, 0, 10, 1); step("w_x10", 4'b1000);
    set_id(1, 10, 1, 0, 0, 0, 0); step("rd_x10", 4'b0110);
    flush_req = 1'b1;             step("flush_in_stall", 4'b0011);
    set_id(1, 11, 1, 0, 0, 0, 0); step("flush_win1", 4'b0010);
    step("flush_win2", 4'b0010);
    step("after_flush", 4'b1000);
    set_id(0, 0, 0, 0, 0, 0, 0);
    retire(10);                   step("ret_x10", 4'b0010);
    set_id(1, 11, 1, 0, 0, 0, 0);
    flush_req = 1'b1;             step("flush2", 4'b0011);
    step("f2_win1", 4'b0010);
    flush_req = 1'b1;             step("f2_reflush", 4'b0011);
    step("f2_win2", 4'b0010);
    step("f2_win3", 4'b0010);
    step("after_flush2", 4'b1000);
    ex_busy = 1'b1;               step("ex_busy", 4'b0110);

    // same-cycle issue and retire on x3 keeps pend at 1
    set_id(1, 0, 0, 0, 0, 3, 1);  step("w_x3", 4'b1000);
    retire(3);                    step("w_x3_ret_same", 4'b1000);
    set_id(1, 3, 1, 0, 0, 0, 0);  step("rd_x3_pend1", 4'b0110);
    retire(3);                    step("rd_x3_bypass", 4'b1000);
    step("rd_x3_pend0", 4'b1000);

    // reset while stalled clears the scoreboard
    set_id(1, 0, 0, 0, 0, 4, 1);  step("w_x4", 4'b1000);
    set_id(1, 4, 1, 0, 0, 0, 0);  step("rd_x4", 4'b0110);
    reset = 1'b1;                 step("rst_mid", 4'b0000);
    reset = 1'b0;                 step("rst_release", 4'b1000);

`ifdef ISSUE_SCOREBOARD_PERF_EN
    reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);  step("perf_rst", 4'b0000);
    reset = 1'b0;
    set_id(1, 0, 0, 0, 0, 12, 1); step("perf_w_x12", 4'b1000);
    set_id(1, 12, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("perf_stall", 4'b0110);
    set_id(0, 0, 0, 0, 0, 0, 0);
    flush_req = 1'b1;             step("perf_flush1", 4'b0011);
    step("perf_fwin", 4'b0010);
    flush_req = 1'b1;             step("perf_flush2", 4'b0011);
    step("perf_fwin", 4'b0010);
    check("stall_cycles", stall_cycles, 32'd5);
    check("flush_count", flush_count, 32'd2);
    check("bubble_cycles", bubble_cycles, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
